// File: rtl/chan_mux_pkg.sv
// Shared mode encoding for the channel selector family.
package chan_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/chan_mux_rr_onehot_dec.sv
// Index to one-hot decoder; an index outside 0..N-1 decodes to all zeros.
module onehot_dec #(
  parameter int N    = 4,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [SELW-1:0] idx,
  output logic [N-1:0]    oh
);

  always_comb begin
    oh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == SELW'(i)) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// NCH-channel registered selector: fixed select or round-robin over valid channels,
// with one registered output beat and a valid/ready handshake on both sides.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      cur_ch
);

  logic [SELW-1:0]  ptr;
  logic [NCH-1:0]   fix_grant;
  logic [NCH-1:0]   rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic             rr_hit;
  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gidx;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  onehot_dec #(.N(NCH), .SELW(SELW)) u_dec (
    .idx (sel),
    .oh  (fix_grant)
  );

  // Priority search starting at ptr; candidate index wraps explicitly so
  // non-power-of-2 channel counts never visit a nonexistent channel.
  always_comb begin : rr_find
    int unsigned c;
    c        = 0;
    rr_hit   = 1'b0;
    rr_idx   = '0;
    rr_grant = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = 32'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!rr_hit && in_valid[c]) begin
        rr_hit      = 1'b1;
        rr_idx      = SELW'(c);
        rr_grant[c] = 1'b1;
      end
    end
  end

  always_comb begin
    grant    = (mode == MODE_RR) ? rr_grant : fix_grant;
    gidx     = (mode == MODE_RR) ? rr_idx   : sel;
    load_en  = !out_valid || out_ready;
    in_ready = (rst_n && load_en) ? (grant & in_valid) : '0;
    xfer     = |in_ready;
  end

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (in_ready[i]) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cur_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_data;
        cur_ch   <= gidx;
        if (mode == MODE_RR)
          ptr <= (gidx == SELW'(NCH - 1)) ? '0 : gidx + SELW'(1);
      end
    end
  end

endmodule
